// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR draw arbiter.
// The optional seed port is enabled by defining LFSR_DRAW_SEED_EN.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 8;

  localparam logic [LFSR_WIDTH-1:0] LFSR_RESET = 8'h01;

  // Feedback taps: bits 0, 2, 3 and 4 of the current state.
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'b0001_1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    RESP = 2'd2
  } lfsr_draw_state_t;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(
    input logic [LFSR_WIDTH-1:0] s
  );
    return {^(s & LFSR_TAPS), s[LFSR_WIDTH-1:1]};
  endfunction

endpackage

// File: rtl/lfsr_draw_arbiter_core.sv
// The 8-bit Fibonacci LFSR register shared by all requesters.
// A zero seed is replaced by the reset value so the register never locks up.
import lfsr_pkg::*;

module lfsr_step_core (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_en,
  input  logic                  load_en,
  input  logic [LFSR_WIDTH-1:0] load_data,
  output logic [LFSR_WIDTH-1:0] state
);

  logic [LFSR_WIDTH-1:0] state_q;
  logic [LFSR_WIDTH-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_en) begin
      if (load_data == '0) begin
        state_d = LFSR_RESET;
      end else begin
        state_d = load_data;
      end
    end else if (step_en) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LFSR_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_draw_arbiter.sv
// Round-robin arbiter handing out one fresh LFSR byte per request.
// Define LFSR_DRAW_SEED_EN to add the seed_valid/seed_data/seed_ready port.
import lfsr_pkg::*;

module lfsr_draw_arbiter #(
  parameter int N     = 4,
  parameter int STEPS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [N-1:0]          rsp_grant,
  output logic [LFSR_WIDTH-1:0] rsp_data,
  output logic                  busy
`ifdef LFSR_DRAW_SEED_EN
  ,
  input  logic                  seed_valid,
  input  logic [LFSR_WIDTH-1:0] seed_data,
  output logic                  seed_ready
`endif
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = 4;

  lfsr_draw_state_t state_q;
  lfsr_draw_state_t state_d;

  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         ptr_d;
  logic [PW-1:0]         win_q;
  logic [PW-1:0]         win_d;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic [N-1:0]          grant_q;
  logic [N-1:0]          grant_d;
  logic [LFSR_WIDTH-1:0] data_q;
  logic [LFSR_WIDTH-1:0] data_d;
  logic                  valid_q;
  logic                  valid_d;
  logic                  busy_q;
  logic                  busy_d;

  logic                  hit;
  logic [PW-1:0]         pick;
  logic [PW-1:0]         cand;
  logic [N-1:0]          grant_one;

  logic                  step_en;
  logic                  load_en;
  logic [LFSR_WIDTH-1:0] load_data;
  logic [LFSR_WIDTH-1:0] lfsr_state;

`ifdef LFSR_DRAW_SEED_EN
  assign seed_ready = seed_valid && (state_q == IDLE);
  assign load_en    = seed_ready;
  assign load_data  = seed_data;
`else
  assign load_en    = 1'b0;
  assign load_data  = LFSR_RESET;
`endif

  lfsr_step_core u_core (
    .clk       (clk),
    .rst       (rst),
    .step_en   (step_en),
    .load_en   (load_en),
    .load_data (load_data),
    .state     (lfsr_state)
  );

  // Search starts one past the last winner and wraps modulo N.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    cand = '0;
    for (int i = 1; i <= N; i++) begin
      cand = PW'((int'(ptr_q) + i) % N);
      if (!hit && req[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  always_comb begin
    grant_one       = '0;
    grant_one[pick] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    data_d  = data_q;
    valid_d = valid_q;
    step_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_en) begin
          state_d = IDLE;
        end else if (hit) begin
          win_d   = pick;
          grant_d = grant_one;
          cnt_d   = '0;
          state_d = STEP;
        end
      end
      STEP: begin
        step_en = 1'b1;
        if (cnt_q == CW'(STEPS - 1)) begin
          // Capture the value the register takes on this same edge.
          data_d  = lfsr_next(lfsr_state);
          valid_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (valid_q && rsp_ready) begin
          ptr_d   = win_q;
          grant_d = '0;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= PW'(N - 1);
      win_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_grant = grant_q;
  assign rsp_data  = data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lfsr_draw_arbiter.sv
// Scoreboard bench for lfsr_draw_arbiter (seed tests need LFSR_DRAW_SEED_EN).
// Expected draws are queued on stimulus and compared at each handshake.
`timescale 1ns/1ps

module tb_lfsr_draw_arbiter;

  localparam int N     = 4;
  localparam int STEPS = 4;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] d;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_grant;
  logic [7:0] rsp_data;
  logic       busy;
`ifdef LFSR_DRAW_SEED_EN
  logic       seed_valid;
  logic [7:0] seed_data;
  logic       seed_ready;
`endif

  exp_t sb[$];
  int   rises[$];
  int   n_checks;
  int   n_errors;
  int   hs_cnt;
  int   tcnt;
  int   m_ptr;
  logic [7:0] m_lfsr;
  logic prev_valid;

  lfsr_draw_arbiter #(.N(N), .STEPS(STEPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_grant (rsp_grant),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef LFSR_DRAW_SEED_EN
    ,
    .seed_valid(seed_valid),
    .seed_data (seed_data),
    .seed_ready(seed_ready)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mstep(input logic [7:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
  endfunction

  task automatic model_draw(input logic [3:0] r, output exp_t e);
    int k;
    k = m_ptr;
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (m_ptr + i) % N;
      if (r[c]) begin
        k = c;
        break;
      end
    end
    m_ptr = k;
    repeat (STEPS) m_lfsr = mstep(m_lfsr);
    e.g = 4'b0001 << k;
    e.d = m_lfsr;
  endtask

  // Samples at the negedge with this cycle's inputs already driven.
  task automatic step();
    exp_t e;
    tcnt++;
    if (rsp_valid && !prev_valid) rises.push_back(tcnt);
    prev_valid = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(rsp_grant), 32'hffff);
      end else begin
        e = sb.pop_front();
        check("rsp_grant", 32'(rsp_grant), 32'(e.g));
        check("rsp_data", 32'(rsp_data), 32'(e.d));
      end
      hs_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic wait_hs(input int target);
    int b;
    b = 0;
    while (hs_cnt < target && b < 300) begin
      step();
      b++;
    end
    check("hs_count", hs_cnt, target);
    req = '0;
  endtask

  task automatic settle();
    step();
    step();
    check("busy_idle", 32'(busy), 0);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    rsp_ready = 1'b0;
`ifdef LFSR_DRAW_SEED_EN
    seed_valid = 1'b0;
    seed_data = '0;
`endif
    #1;
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_grant", 32'(rsp_grant), 0);
    check("rst_data", 32'(rsp_data), 0);
    check("rst_busy", 32'(busy), 0);
`ifdef LFSR_DRAW_SEED_EN
    check("rst_seed_ready", 32'(seed_ready), 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = 8'h01;
    m_ptr = N - 1;
    prev_valid = 1'b0;
    rises.delete();
  endtask

  initial begin
    exp_t e;
    int start;
    n_checks = 0;
    n_errors = 0;
    hs_cnt = 0;
    tcnt = 0;
    do_reset();

    // single requester: 8'h10 then 8'h71, latency STEPS+1
    start = tcnt + 1;
    model_draw(4'b0001, e);
    sb.push_back(exp_t'({4'b0001, 8'h10}));
    model_draw(4'b0001, e);
    sb.push_back(exp_t'({4'b0001, 8'h71}));
    req = 4'b0001;
    rsp_ready = 1'b1;
    wait_hs(hs_cnt + 2);
    settle();
    check("rise_count_1", rises.size(), 2);
    if (rises.size() >= 2) begin
      check("latency", rises[0] - start, STEPS + 1);
      check("gap_1", rises[1] - rises[0], STEPS + 2);
    end

    // round robin from reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      model_draw(4'b1111, e);
      sb.push_back(e);
    end
    req = 4'b1111;
    rsp_ready = 1'b1;
    wait_hs(hs_cnt + 5);
    settle();
    check("rise_count_rr", rises.size(), 5);
    for (int i = 1; i < 5 && i < rises.size(); i++)
      check("gap_rr", rises[i] - rises[i-1], STEPS + 2);

    // backpressure: response held for 10 cycles
    model_draw(4'b0010, e);
    sb.push_back(e);
    req = 4'b0010;
    rsp_ready = 1'b0;
    begin
      int b;
      b = 0;
      while (!rsp_valid && b < 50) begin
        step();
        b++;
      end
    end
    check("bp_valid_seen", 32'(rsp_valid), 1);
    repeat (10) begin
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_busy", 32'(busy), 1);
      if (sb.size() > 0) begin
        check("bp_grant", 32'(rsp_grant), 32'(sb[0].g));
        check("bp_data", 32'(rsp_data), 32'(sb[0].d));
      end
      step();
    end
    rsp_ready = 1'b1;
    wait_hs(hs_cnt + 1);
    settle();
    model_draw(4'b0010, e);
    sb.push_back(e);
    req = 4'b0010;
    wait_hs(hs_cnt + 1);
    settle();

    // requester pulses req for one cycle
    model_draw(4'b0100, e);
    sb.push_back(e);
    req = 4'b0100;
    rsp_ready = 1'b1;
    step();
    req = '0;
    wait_hs(hs_cnt + 1);
    settle();

`ifdef LFSR_DRAW_SEED_EN
    // zero seed maps to 8'h01
    seed_valid = 1'b1;
    seed_data = 8'h00;
    #1;
    check("seed_ready_idle", 32'(seed_ready), 1);
    step();
    seed_valid = 1'b0;
    m_lfsr = 8'h01;
    model_draw(4'b0001, e);
    sb.push_back(exp_t'({e.g, 8'h10}));
    req = 4'b0001;
    wait_hs(hs_cnt + 1);
    settle();

    // seed during STEP is ignored
    model_draw(4'b0001, e);
    sb.push_back(e);
    req = 4'b0001;
    start = hs_cnt + 1;
    step();
    step();
    seed_valid = 1'b1;
    seed_data = 8'h55;
    #1;
    check("seed_ready_step", 32'(seed_ready), 0);
    check("busy_step", 32'(busy), 1);
    step();
    seed_valid = 1'b0;
    wait_hs(start);
    settle();

    // seed wins over a same-cycle request
    seed_valid = 1'b1;
    seed_data = 8'ha5;
    req = 4'b0001;
    start = hs_cnt + 1;
    step();
    seed_valid = 1'b0;
    m_lfsr = 8'ha5;
    model_draw(4'b0001, e);
    sb.push_back(e);
    wait_hs(start);
    settle();
`endif

    // reset during STEP
    req = 4'b0001;
    rsp_ready = 1'b1;
    step();
    step();
    check("pre_rst_busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_grant", 32'(rsp_grant), 0);
    check("mid_rst_data", 32'(rsp_data), 0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = 8'h01;
    m_ptr = N - 1;
    prev_valid = 1'b0;
    model_draw(4'b0001, e);
    sb.push_back(exp_t'({4'b0001, 8'h10}));
    req = 4'b0001;
    wait_hs(hs_cnt + 1);
    settle();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
